// File: rtl/tmds_pkg.sv
// TMDS shared definitions: control tokens, token lookup, aligner states.
// Used by both the encoder and the decoder.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

  typedef enum logic {
    SEARCH,
    LOCKED
  } align_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] cd;
  } ctrl_tok_t;

  function automatic ctrl_tok_t CTRL_TOKEN(input logic [9:0] w);
    ctrl_tok_t r;
    r.valid = 1'b1;
    r.cd    = 2'b00;
    unique case (w)
      CTRL_TOK_00: r.cd = 2'b00;
      CTRL_TOK_01: r.cd = 2'b01;
      CTRL_TOK_10: r.cd = 2'b10;
      CTRL_TOK_11: r.cd = 2'b11;
      default:     r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmds_word_aligner.sv
// TMDS word aligner: hunts for control-token runs across the ten bit
// offsets of a two-word window and freezes the offset once locked.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int LOCK_CNT     = 8,
  parameter int DWELL        = 2048,
  parameter int LOSS_TIMEOUT = 2097152
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] tmds_i,
  output logic [9:0] word_o,
  output logic       locked_o,
  output logic       lock_nxt_o,
  output logic       drop_o,
  output logic [3:0] offset_o
);

  localparam int HW = $clog2(LOCK_CNT) + 1;
  localparam int DW = $clog2(DWELL) + 1;
  localparam int LW = $clog2(LOSS_TIMEOUT) + 1;

  localparam logic [HW-1:0] HIT_MAX   = HW'(LOCK_CNT);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL);
  localparam logic [LW-1:0] LOSS_MAX  = LW'(LOSS_TIMEOUT);

  align_state_e  state_q, state_d;
  logic [9:0]    prev_q;
  logic [3:0]    off_q, off_d;
  logic [HW-1:0] hit_q, hit_d, hit_inc;
  logic [DW-1:0] dwell_q, dwell_d, dwell_inc;
  logic [LW-1:0] loss_q, loss_d, loss_inc;
  logic [19:0]   window;
  ctrl_tok_t     tok;
  logic          run_done;

  assign window   = {tmds_i, prev_q};
  assign word_o   = window[off_q +: 10];
  assign tok      = CTRL_TOKEN(word_o);

  // Saturating increments; counters never wrap.
  assign hit_inc   = (hit_q == '1) ? hit_q : hit_q + 1'b1;
  assign dwell_inc = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;
  assign loss_inc  = (loss_q == '1) ? loss_q : loss_q + 1'b1;
  assign run_done  = tok.valid && (hit_inc >= HIT_MAX);

  assign locked_o   = (state_q == LOCKED);
  assign lock_nxt_o = (state_d == LOCKED);
  assign drop_o     = (state_q == LOCKED) && (state_d == SEARCH);
  assign offset_o   = off_q;

  // Lock hunt / loss-of-lock next-state logic.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    hit_d   = hit_q;
    dwell_d = dwell_q;
    loss_d  = loss_q;
    unique case (state_q)
      SEARCH: begin
        if (tok.valid) begin
          hit_d = hit_inc;
        end else begin
          hit_d   = '0;
          dwell_d = dwell_inc;
        end
        if (run_done) begin
          state_d = LOCKED;
          hit_d   = '0;
          loss_d  = '0;
          dwell_d = '0;
        end else if (!tok.valid && dwell_inc >= DWELL_MAX) begin
          off_d   = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
          dwell_d = '0;
          hit_d   = '0;
        end
      end
      LOCKED: begin
        hit_d  = tok.valid ? hit_inc : '0;
        loss_d = loss_inc;
        if (run_done) begin
          loss_d = '0;
        end else if (loss_inc >= LOSS_MAX) begin
          state_d = SEARCH;
          dwell_d = '0;
          hit_d   = '0;
          loss_d  = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Aligner state, previous word and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEARCH;
      prev_q  <= '0;
      off_q   <= '0;
      hit_q   <= '0;
      dwell_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= tmds_i;
      off_q   <= off_d;
      hit_q   <= hit_d;
      dwell_q <= dwell_d;
      loss_q  <= loss_d;
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: word alignment, token match and 10b->8b decode.
// Define TMDS_DEC_RELOCK_CNT_EN to count LOCKED->SEARCH transitions.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_CNT     = 8,
  parameter int DWELL        = 2048,
  parameter int LOSS_TIMEOUT = 2097152
) (
  input  logic       TMDS_local_clk,
  input  logic       TMDS_local_rst,
  input  logic [9:0] TMDS_in,
  output logic [7:0] VD,
  output logic [1:0] CD,
  output logic       VDE,
  output logic       locked,
  output logic [3:0] bit_offset,
  output logic [7:0] relock_cnt
);

  logic [9:0] a;
  logic       al_locked;
  logic       lock_nxt;
  logic       drop;
  ctrl_tok_t  tok;
  logic [7:0] q;
  logic [7:0] dec;
  logic [7:0] vd_q, vd_d;
  logic [1:0] cd_q, cd_d;
  logic       vde_q, vde_d;

  tmds_word_aligner #(
    .LOCK_CNT     (LOCK_CNT),
    .DWELL        (DWELL),
    .LOSS_TIMEOUT (LOSS_TIMEOUT)
  ) u_aligner (
    .clk_i      (TMDS_local_clk),
    .rst_i      (TMDS_local_rst),
    .tmds_i     (TMDS_in),
    .word_o     (a),
    .locked_o   (al_locked),
    .lock_nxt_o (lock_nxt),
    .drop_o     (drop),
    .offset_o   (bit_offset)
  );

  assign tok = CTRL_TOKEN(a);
  assign q   = a[9] ? ~a[7:0] : a[7:0];

  // Undo the transition-minimising XOR/XNOR chain.
  always_comb begin
    dec    = '0;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = a[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // Output select; gated by the upcoming lock state so outputs track locked.
  always_comb begin
    vd_d  = vd_q;
    cd_d  = cd_q;
    vde_d = vde_q;
    if (!lock_nxt) begin
      vd_d  = '0;
      cd_d  = '0;
      vde_d = 1'b0;
    end else if (tok.valid) begin
      vde_d = 1'b0;
      cd_d  = tok.cd;
    end else begin
      vde_d = 1'b1;
      vd_d  = dec;
    end
  end

  // Output registers.
  always_ff @(posedge TMDS_local_clk) begin
    if (TMDS_local_rst) begin
      vd_q  <= '0;
      cd_q  <= '0;
      vde_q <= 1'b0;
    end else begin
      vd_q  <= vd_d;
      cd_q  <= cd_d;
      vde_q <= vde_d;
    end
  end

  assign VD     = vd_q;
  assign CD     = cd_q;
  assign VDE    = vde_q;
  assign locked = al_locked;

`ifdef TMDS_DEC_RELOCK_CNT_EN
  logic [7:0] relock_q;

  // Saturating count of lock losses; cleared only by reset.
  always_ff @(posedge TMDS_local_clk) begin
    if (TMDS_local_rst) begin
      relock_q <= '0;
    end else if (drop && relock_q != 8'hFF) begin
      relock_q <= relock_q + 8'd1;
    end
  end

  assign relock_cnt = relock_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign relock_cnt  = 8'd0;
`endif

endmodule
